dsp_ar_order_ctrl: RTL and testbench

- Read-order scheduler for one master port of the AXI4 interconnect dispatcher.
- Records the target slave and burst length of every accepted AR transaction in issue order.
- Drives the slave-select and disable inputs of the RDATA channel dispatcher so R beats return to the master in AR order.
- Counts returned beats to retire each burst, and back-pressures AR issue when the outstanding-transaction limit is reached.

---
 rtl/dsp_pkg.sv | 25 ++
 rtl/dsp_ar_order_ctrl_fifo.sv | 67 ++++++
 rtl/dsp_ar_order_ctrl.sv | 162 ++++++++++++++++
 tb/tb_dsp_ar_order_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// -----------------------------------------------------------------------------
// dsp_pkg
// Shared definitions for the AXI4 interconnect dispatcher read-order logic.
//   LEN_W          : AxLEN width (beats - 1)
//   DFLT_SLV_ID_W  : slave index width for the default two-slave build
//   order_entry_t  : one order-queue record {slv_id, len} (default widths)
//   ord_state_e    : read-order scheduler FSM encoding
// -----------------------------------------------------------------------------
package dsp_pkg;

    localparam int unsigned LEN_W         = 8;
    localparam int unsigned DFLT_SLV_ID_W = 1;

    // Field order matches the packing written into the order queue.
    typedef struct packed {
        logic [DFLT_SLV_ID_W-1:0] slv_id;
        logic [LEN_W-1:0]         len;
    } order_entry_t;

    typedef enum logic {
        StIdle,
        StActive
    } ord_state_e;

endpackage

// File: rtl/dsp_ar_order_ctrl_fifo.sv
// -----------------------------------------------------------------------------
// dsp_ar_order_ctrl_fifo
// Order queue for the read-order scheduler. The head entry is visible on
// data_o whenever the queue is not empty. No write/read bypass: a read does
// not free a slot for a write in the same cycle.
// Ports:
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   wr_valid_i       : write data_i at the tail (ignored while full)
//   data_i           : entry to write
//   rd_valid_i       : drop the head entry (ignored while empty)
//   data_o           : head entry
//   full_o, empty_o  : occupancy flags
//   count_o          : number of stored entries (0..FIFO_DEPTH)
// -----------------------------------------------------------------------------
module dsp_ar_order_ctrl_fifo #(
    parameter int unsigned DATA_WIDTH = 9,
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned AW        = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  rd_valid_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [AW:0]           count_o
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  wr_en;
    logic                  rd_en;

    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count_o = wr_ptr - rd_ptr;
    assign data_o  = mem[rd_ptr[AW-1:0]];

    assign wr_en = wr_valid_i & ~full_o;
    assign rd_en = rd_valid_i & ~empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/dsp_ar_order_ctrl.sv
// -----------------------------------------------------------------------------
// dsp_ar_order_ctrl
// Read-order scheduler for one master port of the AXI4 interconnect
// dispatcher. Records {slave, ARLEN} of each issued AR in order, steers the
// RDATA dispatcher to the slave owning the oldest outstanding burst, counts
// returned beats to retire bursts, and back-pressures AR issue when the
// outstanding limit is reached.
//
// Optional feature (macro DSP_AR_LEN_CHECK_EN): compares m_RLAST_i against the
// expected last beat on every R handshake and raises a sticky prot_err_o on any
// mismatch. Without the macro prot_err_o is tied low and m_RLAST_i is unused.
//
// Ports:
//   ACLK_i, ARESETn_i        : clock, asynchronous active-low reset
//   ar_valid_i               : decoded AR request ready to issue
//   ar_slv_id_i, ar_len_i    : target slave and ARLEN of that request
//   ar_ready_o               : order queue can accept (AR issues on valid&ready)
//   dsp_R_handshake_occur_i  : master-side R handshake
//   m_RLAST_i                : RLAST presented to the master
//   dsp_AR_slv_id_o          : slave whose R data is forwarded now
//   dsp_AR_disable_o         : no burst in service; blocks RVALID
//   outst_cnt_o              : bursts queued or in service
//   prot_err_o               : sticky beat-count/RLAST mismatch
// -----------------------------------------------------------------------------
module dsp_ar_order_ctrl #(
    parameter int unsigned SLV_AMT     = 2,
    parameter int unsigned SLV_ID_W    = $clog2(SLV_AMT),
    parameter int unsigned LEN_W       = dsp_pkg::LEN_W,
    parameter int unsigned OUTST_DEPTH = 8,
    localparam int unsigned CNT_W      = $clog2(OUTST_DEPTH) + 1
) (
    input  logic                ACLK_i,
    input  logic                ARESETn_i,
    input  logic                ar_valid_i,
    input  logic [SLV_ID_W-1:0] ar_slv_id_i,
    input  logic [LEN_W-1:0]    ar_len_i,
    output logic                ar_ready_o,
    input  logic                dsp_R_handshake_occur_i,
    input  logic                m_RLAST_i,
    output logic [SLV_ID_W-1:0] dsp_AR_slv_id_o,
    output logic                dsp_AR_disable_o,
    output logic [CNT_W-1:0]    outst_cnt_o,
    output logic                prot_err_o
);

    import dsp_pkg::*;

    localparam int unsigned ENTRY_W = SLV_ID_W + LEN_W;

    logic                fifo_full;
    logic                fifo_empty;
    logic [ENTRY_W-1:0]  head_entry;
    logic [SLV_ID_W-1:0] head_slv;
    logic [LEN_W-1:0]    head_len;
    logic [CNT_W-1:0]    outst_cnt;

    logic                push;
    logic                retire;
    logic                last_beat;
    logic                keep_active;

    ord_state_e          state;
    logic [LEN_W-1:0]    beat_cnt;
    logic                ar_disable;

    // -------------------------------------------------------------------------
    // Order queue
    // -------------------------------------------------------------------------
    assign push = ar_valid_i & ~fifo_full;

    dsp_ar_order_ctrl_fifo #(
        .DATA_WIDTH (ENTRY_W),
        .FIFO_DEPTH (OUTST_DEPTH)
    ) u_order_fifo (
        .clk_i      (ACLK_i),
        .rst_ni     (ARESETn_i),
        .wr_valid_i (push),
        .data_i     ({ar_slv_id_i, ar_len_i}),
        .rd_valid_i (retire),
        .data_o     (head_entry),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (outst_cnt)
    );

    assign head_slv = head_entry[LEN_W +: SLV_ID_W];
    assign head_len = head_entry[LEN_W-1:0];

    // -------------------------------------------------------------------------
    // Beat counting and retirement
    // -------------------------------------------------------------------------
    // Exact compare: a len of all-ones retires on the 2^LEN_W-th beat, no wrap.
    assign last_beat = (beat_cnt == head_len);
    assign retire    = (state == StActive) & dsp_R_handshake_occur_i & last_beat;

    // After a pop another burst is in service if an older entry remains or one
    // is being pushed in the same cycle (that gives the zero-bubble handoff).
    assign keep_active = (outst_cnt > CNT_W'(1)) | push;

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            state      <= StIdle;
            beat_cnt   <= '0;
            ar_disable <= 1'b1;
        end else begin
            unique case (state)
                StIdle: begin
                    beat_cnt <= '0;
                    if (push) begin
                        state      <= StActive;
                        ar_disable <= 1'b0;
                    end
                end
                StActive: begin
                    if (dsp_R_handshake_occur_i) begin
                        if (last_beat) begin
                            beat_cnt <= '0;
                            if (!keep_active) begin
                                state      <= StIdle;
                                ar_disable <= 1'b1;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + LEN_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign ar_ready_o       = ~fifo_full;
    assign dsp_AR_slv_id_o  = fifo_empty ? '0 : head_slv;
    assign dsp_AR_disable_o = ar_disable;
    assign outst_cnt_o      = outst_cnt;

    // -------------------------------------------------------------------------
    // Optional RLAST / beat-count consistency checker
    // -------------------------------------------------------------------------
`ifdef DSP_AR_LEN_CHECK_EN
    logic prot_err;

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            prot_err <= 1'b0;
        end else if ((state == StActive) && dsp_R_handshake_occur_i &&
                     (m_RLAST_i != last_beat)) begin
            prot_err <= 1'b1;
        end
    end

    assign prot_err_o = prot_err;
`else
    logic unused_rlast;

    assign unused_rlast = m_RLAST_i;
    assign prot_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_dsp_ar_order_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dsp_ar_order_ctrl
// Self-checking bench for dsp_ar_order_ctrl (default parameters). A table of
// single-cycle vectors covers single-burst and interleaved ordering; hand-written
// sequences cover full queue, push/pop in the same cycle, asynchronous reset
// and the optional RLAST checker (macro DSP_AR_LEN_CHECK_EN).
// -----------------------------------------------------------------------------
module tb_dsp_ar_order_ctrl;

`ifdef DSP_AR_LEN_CHECK_EN
    localparam logic LEN_CHK = 1'b1;
`else
    localparam logic LEN_CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ar_valid = 1'b0;
    logic [0:0] ar_slv_id = '0;
    logic [7:0] ar_len = '0;
    logic       ar_ready;
    logic       r_hs = 1'b0;
    logic       rlast = 1'b0;
    logic [0:0] slv_sel;
    logic       rd_disable;
    logic [3:0] outst_cnt;
    logic       prot_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dsp_ar_order_ctrl dut (
        .ACLK_i                  (clk),
        .ARESETn_i               (rst_n),
        .ar_valid_i              (ar_valid),
        .ar_slv_id_i             (ar_slv_id),
        .ar_len_i                (ar_len),
        .ar_ready_o              (ar_ready),
        .dsp_R_handshake_occur_i (r_hs),
        .m_RLAST_i               (rlast),
        .dsp_AR_slv_id_o         (slv_sel),
        .dsp_AR_disable_o        (rd_disable),
        .outst_cnt_o             (outst_cnt),
        .prot_err_o              (prot_err)
    );

    typedef struct {
        logic       av;
        logic [0:0] slv;
        logic [7:0] len;
        logic       hs;
        logic       e_ready;
        logic       e_dis;
        logic [0:0] e_slv;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t vecs [11];

    // Apply inputs for one cycle, then sample 1 time unit after the edge.
    task automatic drive(input logic av, input logic [0:0] slv, input logic [7:0] len,
                         input logic hs, input logic rl);
        ar_valid  = av;
        ar_slv_id = slv;
        ar_len    = len;
        r_hs      = hs;
        rlast     = rl;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic er, input logic ed,
                       input logic [0:0] es, input logic [3:0] ec);
        checks++;
        if (ar_ready !== er || rd_disable !== ed || slv_sel !== es || outst_cnt !== ec) begin
            errors++;
            $display("FAIL %s: got ready=%0b disable=%0b slv=%0d cnt=%0d, want ready=%0b disable=%0b slv=%0d cnt=%0d",
                     nm, ar_ready, rd_disable, slv_sel, outst_cnt, er, ed, es, ec);
        end
    endtask

    task automatic chk_prot(input string nm, input logic ep);
        checks++;
        if (prot_err !== ep) begin
            errors++;
            $display("FAIL %s: got prot_err=%0b, want %0b", nm, prot_err, ep);
        end
    endtask

    initial begin
        // Single burst slv 1 len 3, then interleaved slv 0 len 1 / slv 1 len 0.
        //            av    slv   len   hs    rdy   dis   slv   cnt
        vecs[0]  = '{1'b1, 1'b1, 8'd3, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1};
        vecs[1]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1};
        vecs[2]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1};
        vecs[3]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1};
        vecs[4]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0};
        vecs[5]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0};
        vecs[6]  = '{1'b1, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
        vecs[7]  = '{1'b1, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2};
        vecs[8]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2};
        vecs[9]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1};
        vecs[10] = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 1'b1, 1'b1, 1'b0, 4'd0);
        chk_prot("reset_prot", 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
            chk($sformatf("idle%0d", i), 1'b1, 1'b1, 1'b0, 4'd0);
        end

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].av, vecs[i].slv, vecs[i].len, vecs[i].hs, 1'b0);
            chk($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_dis, vecs[i].e_slv,
                vecs[i].e_cnt);
        end

        // Full queue: eight len-0 pushes, slave alternating 0,1,0,1...
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'(i % 2), 8'd0, 1'b0, 1'b0);
            chk($sformatf("fill%0d", i), (i < 7), 1'b0, 1'b0, 4'(i + 1));
        end
        drive(1'b1, 1'b1, 8'd5, 1'b0, 1'b0);
        chk("reject9", 1'b0, 1'b0, 1'b0, 4'd8);
        // Pop while full: the concurrent push must still be refused.
        drive(1'b1, 1'b1, 8'd0, 1'b1, 1'b0);
        chk("retire_full", 1'b1, 1'b0, 1'b1, 4'd7);
        for (int i = 1; i < 8; i++) begin
            drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
            chk($sformatf("drain%0d", i), 1'b1, (i == 7), (i == 7) ? 1'b0 : 1'((i + 1) % 2),
                4'(7 - i));
        end

        // Push and pop in the same cycle with one entry outstanding.
        drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        chk("sp_push", 1'b1, 1'b0, 1'b0, 4'd1);
        drive(1'b1, 1'b1, 8'd2, 1'b1, 1'b0);
        chk("sp_same", 1'b1, 1'b0, 1'b1, 4'd1);
        drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        chk("sp_beat", 1'b1, 1'b0, 1'b1, 4'd1);

        // Asynchronous reset mid-burst, observed without a clock edge.
        rst_n = 1'b0;
        #1;
        chk("async_rst", 1'b1, 1'b1, 1'b0, 4'd0);
        chk_prot("async_rst_prot", 1'b0);
        drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        chk("post_rst", 1'b1, 1'b1, 1'b0, 4'd0);

        // RLAST early on beat 2 of a 3-beat burst.
        drive(1'b1, 1'b1, 8'd2, 1'b0, 1'b0);
        chk("pe_push", 1'b1, 1'b0, 1'b1, 4'd1);
        drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        chk_prot("pe_beat1", 1'b0);
        drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
        chk_prot("pe_beat2", LEN_CHK);
        chk("pe_beat2_busy", 1'b1, 1'b0, 1'b1, 4'd1);
        drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        chk("pe_retire", 1'b1, 1'b1, 1'b0, 4'd0);
        chk_prot("pe_retire_prot", LEN_CHK);
        drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        chk_prot("pe_sticky", LEN_CHK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
